// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, write-to-read bypass and a
// pending-write scoreboard that tracks registers reserved at issue.
module regfile_scoreboard #(
  parameter int WORD_LENGTH = 32,
  parameter int N           = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter bit ZERO_REG    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [ADDR_WIDTH-1:0]  WriteRegister,
  input  logic [WORD_LENGTH-1:0] WriteData,
  input  logic                   Reserve,
  input  logic [ADDR_WIDTH-1:0]  ReserveRegister,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister2,
  output logic [WORD_LENGTH-1:0] ReadData1,
  output logic [WORD_LENGTH-1:0] ReadData2,
  output logic                   Busy1,
  output logic                   Busy2,
  output logic [ADDR_WIDTH:0]    PendingCount
);

  logic [WORD_LENGTH-1:0] r_regs [N];
  logic [N-1:0]           r_pending;
  logic [ADDR_WIDTH:0]    r_count;

  logic w_we;
  logic w_rv;
  logic w_wz;
  logic w_rz;
  logic w_inc;
  logic w_dec;
  logic w_same;

  assign w_wz = ZERO_REG && (WriteRegister == '0);
  assign w_rz = ZERO_REG && (ReserveRegister == '0);
  assign w_we = RegWrite & ~reset & ~w_wz;
  assign w_rv = Reserve & ~reset & ~w_rz;

  // Set wins over clear on the same register, so the count nets to zero.
  assign w_same = w_rv & (ReserveRegister == WriteRegister);
  assign w_inc  = w_rv & ~r_pending[ReserveRegister];
  assign w_dec  = w_we & r_pending[WriteRegister] & ~w_same;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (w_we) begin
        r_regs[WriteRegister]    <= WriteData;
        r_pending[WriteRegister] <= 1'b0;
      end
      if (w_rv) begin
        r_pending[ReserveRegister] <= 1'b1;
      end
      r_count <= r_count
               + {{ADDR_WIDTH{1'b0}}, w_inc}
               - {{ADDR_WIDTH{1'b0}}, w_dec};
    end
  end

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = w_we & (WriteRegister == ReadRegister1);
  assign w_hit2 = w_we & (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = r_regs[ReadRegister1];
    if (ZERO_REG && (ReadRegister1 == '0)) begin
      ReadData1 = '0;
    end else if (w_hit1) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = r_regs[ReadRegister2];
    if (ZERO_REG && (ReadRegister2 == '0)) begin
      ReadData2 = '0;
    end else if (w_hit2) begin
      ReadData2 = WriteData;
    end
  end

  assign Busy1        = r_pending[ReadRegister1] & ~w_hit1;
  assign Busy2        = r_pending[ReadRegister2] & ~w_hit2;
  assign PendingCount = r_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against an
// array-based reference model of registers and pending flags.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Reserve;
  logic [4:0]  ReserveRegister;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy1;
  logic        Busy2;
  logic [5:0]  PendingCount;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_mem  [32];
  bit          m_pend [32];

  regfile_scoreboard #(
    .WORD_LENGTH(32),
    .N(32),
    .ADDR_WIDTH(5),
    .ZERO_REG(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .Reserve(Reserve),
    .ReserveRegister(ReserveRegister),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .Busy1(Busy1),
    .Busy2(Busy2),
    .PendingCount(PendingCount)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_we();
    return RegWrite && !reset && WriteRegister != 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && WriteRegister == a) return WriteData;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (m_we() && WriteRegister == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    foreach (m_pend[i]) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic idle();
    reset    = 1'b0;
    RegWrite = 1'b0;
    Reserve  = 1'b0;
  endtask

  // Inputs are driven at negedge; outputs checked just after.
  task automatic cycle();
    #1;
    check("rd1", ReadData1, m_rd(ReadRegister1));
    check("rd2", ReadData2, m_rd(ReadRegister2));
    check("busy1", 32'(Busy1), 32'(m_busy(ReadRegister1)));
    check("busy2", 32'(Busy2), 32'(m_busy(ReadRegister2)));
    check("cnt", 32'(PendingCount), 32'(m_count()));
    @(posedge clk);
    if (reset) begin
      foreach (m_mem[i]) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (m_we()) begin
        m_mem[WriteRegister]  = WriteData;
        m_pend[WriteRegister] = 1'b0;
      end
      if (Reserve && ReserveRegister != 0) begin
        m_pend[ReserveRegister] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (m_mem[i]) begin
      m_mem[i]  = 'x;
      m_pend[i] = 1'b0;
    end
    idle();
    WriteRegister   = '0;
    WriteData       = '0;
    ReserveRegister = '0;
    ReadRegister1   = '0;
    ReadRegister2   = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    foreach (m_mem[i]) m_mem[i] = '0;
    @(negedge clk);
    idle();

    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(31 - a);
      cycle();
    end
    #1 check("cnt_rst", 32'(PendingCount), 32'd0);

    RegWrite = 1'b1; WriteRegister = 5'd0;
    WriteData = 32'hDEADBEEF; ReadRegister1 = 5'd0;
    #1 check("r0_byp", ReadData1, 32'h0);
    cycle();
    idle();
    #1 check("r0_rd", ReadData1, 32'h0);
    check("r0_busy", 32'(Busy1), 32'd0);

    RegWrite = 1'b1; WriteRegister = 5'd5;
    WriteData = 32'h12345678;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    #1 check("r5_byp1", ReadData1, 32'h12345678);
    check("r5_byp2", ReadData2, 32'h12345678);
    cycle();
    idle();
    #1 check("r5_st", ReadData1, 32'h12345678);
    cycle();
    #1 check("r5_st2", ReadData2, 32'h12345678);

    Reserve = 1'b1; ReserveRegister = 5'd7;
    ReadRegister1 = 5'd7;
    #1 check("r7_busy0", 32'(Busy1), 32'd0);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("r7_busy", 32'(Busy1), 32'd1);
      check("r7_cnt", 32'(PendingCount), 32'd1);
      cycle();
    end
    RegWrite = 1'b1; WriteRegister = 5'd7;
    WriteData = 32'hA5A5A5A5;
    #1 check("r7_wbusy", 32'(Busy1), 32'd0);
    check("r7_wdata", ReadData1, 32'hA5A5A5A5);
    cycle();
    idle();
    #1 check("r7_cnt0", 32'(PendingCount), 32'd0);

    Reserve = 1'b1; ReserveRegister = 5'd3;
    cycle();
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h3;
    cycle();
    idle();
    ReadRegister1 = 5'd3;
    #1 check("r3_busy", 32'(Busy1), 32'd1);
    check("r3_cnt", 32'(PendingCount), 32'd1);
    Reserve = 1'b1; ReserveRegister = 5'd9;
    cycle();
    ReserveRegister = 5'd4;
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h9;
    cycle();
    idle();
    #1 check("r4r9_cnt", 32'(PendingCount), 32'd2);

    for (int a = 1; a < 32; a++) begin
      Reserve = 1'b1; ReserveRegister = 5'(a);
      cycle();
    end
    idle();
    #1 check("all_cnt", 32'(PendingCount), 32'd31);
    Reserve = 1'b1; ReserveRegister = 5'd1;
    cycle();
    idle();
    #1 check("rer1_cnt", 32'(PendingCount), 32'd31);
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h1;
    cycle();
    idle();
    #1 check("wr0_cnt", 32'(PendingCount), 32'd31);

    reset = 1'b1;
    cycle();
    idle();
    Reserve = 1'b1; ReserveRegister = 5'd2;
    cycle();
    ReserveRegister = 5'd6;
    cycle();
    idle();
    reset = 1'b1; RegWrite = 1'b1;
    WriteRegister = 5'd2; WriteData = 32'hFFFF0000;
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd6;
    #1 check("rst_nobyp", ReadData1, 32'h0);
    cycle();
    idle();
    #1 check("rst_rd2", ReadData1, 32'h0);
    check("rst_b1", 32'(Busy1), 32'd0);
    check("rst_b2", 32'(Busy2), 32'd0);
    check("rst_cnt", 32'(PendingCount), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(99) < 2);
      RegWrite        = ($urandom_range(99) < 50);
      Reserve         = ($urandom_range(99) < 40);
      WriteRegister   = 5'($urandom);
      WriteData       = $urandom;
      ReserveRegister = 5'($urandom);
      ReadRegister1   = 5'($urandom);
      ReadRegister2   = ($urandom_range(3) == 0)
                      ? WriteRegister : 5'($urandom);
      if ($urandom_range(7) == 0) ReserveRegister = WriteRegister;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the core register file: N-entry, WORD_LENGTH-bit storage with two combinational read ports, one write port, optional hardwired zero register, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. Sits between decode/issue and writeback. Issue reserves a destination, writeback writes and releases it, and the read ports report whether each operand is still awaited.

## Interface
- WORD_LENGTH, 32, data width in bits.
- N, 32, number of registers (power of two, ≥2).
- ADDR_WIDTH, 5, register address width; equals log2(N).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWrite  in  1  write enable (writeback).
- WriteRegister  in  ADDR_WIDTH  write address.
- WriteData  in  WORD_LENGTH  write data.
- Reserve  in  1  mark ReserveRegister pending (issue).
- ReserveRegister  in  ADDR_WIDTH  register to reserve.
- ReadRegister1  in  ADDR_WIDTH  read port 1 address.
- ReadRegister2  in  ADDR_WIDTH  read port 2 address.
- ReadData1  out  WORD_LENGTH  read port 1 data (combinational).
- ReadData2  out  WORD_LENGTH  read port 2 data (combinational).
- Busy1  out  1  operand 1 awaits a write not yet presented.
- Busy2  out  1  operand 2 awaits a write not yet presented.
- PendingCount  out  ADDR_WIDTH+1  number of pending registers (0..N).

## Operation
- Effective write `we = RegWrite & ~reset & ~(ZERO_REG & WriteRegister==0)`.
- Effective reserve `rv = Reserve & ~reset & ~(ZERO_REG & ReserveRegister==0)`.
- Storage: on edge, if `we`, regs[WriteRegister] <= WriteData.
- Read port k (k = 1, 2):
  - ZERO_REG and address 0 -> 0.
  - Else if `we` and WriteRegister == ReadRegisterk -> WriteData (bypass).
  - Else regs[ReadRegisterk].
- Both ports may address the same register; both return identical data and busy.
- Scoreboard pending[N-1:0], updated on edge:
  - `we` clears pending[WriteRegister].
  - `rv` sets pending[ReserveRegister].
  - Same register written and reserved in one cycle: set wins, so the bit ends at 1.
  - Write to a non-pending register is legal: data stored, pending unchanged.
  - Reserve of an already-pending register: no change.
- Busyk = pending[ReadRegisterk] & ~(`we` & WriteRegister == ReadRegisterk). A bypassed write hides busy in the same cycle.
- PendingCount tracks popcount(pending), maintained incrementally:
  - +1 when `rv` targets a non-pending register.
  - −1 when `we` clears a pending register that is not simultaneously reserved.
  - Net 0 otherwise, including set+clear of the same register.
  - Never exceeds N and never underflows.

## Timing
- Reset: on edge with reset=1, all regs <= 0, pending <= 0, PendingCount <= 0. Writes and reserves in that cycle are discarded.
- While reset=1, bypass is disabled; reads return stored contents.
- Cycle after reset: ReadData1/2 = 0, Busy1/2 = 0, PendingCount = 0.
- Reset mid-operation drops all in-flight reservations with no error indication.
- Read latency is 0 cycles (combinational from address, stored data, and bypass).
- Write latency: data visible in the same cycle via bypass, and from storage from the next cycle onward.
- Reserve latency: Busy asserts the cycle after Reserve; PendingCount updates the same edge.
- No handshake stall: the block never back-pressures. Issue logic must gate on Busy.

## Test plan
- Reset, then read all addresses -> ReadData=0, Busy=0, PendingCount=0. With ZERO_REG=1, write 0xDEADBEEF to r0 -> r0 still reads 0 and Busy stays 0.
- Write 0x12345678 to r5 with ReadRegister1=5 in the same cycle -> ReadData1=0x12345678 that cycle (bypass) and every later cycle; ReadRegister2=5 gives identical data.
- Reserve r7, then hold 3 cycles -> Busy1 (ReadRegister1=7) = 1 from the next cycle, PendingCount=1. Write 0xA5A5A5A5 to r7 -> Busy1=0 that cycle, ReadData1=0xA5A5A5A5, PendingCount=0 next cycle.
- Same cycle: reserve r3 and write r3 (r3 pending) -> next cycle Busy=1, PendingCount unchanged. Reserve r4 while writing pending r9 -> PendingCount unchanged.
- Reserve all 31 non-zero registers (ZERO_REG=1) -> PendingCount=31. Re-reserve r1 -> stays 31. Write to non-pending r0 -> stays 31.
- With r2 and r6 pending, assert reset alongside a write to r2 -> next cycle all data 0, Busy=0, PendingCount=0, and r2 not written.
